// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : stack_pkg
// Brief   : Shared op codes, requester IDs and FSM encoding for stack_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
package stack_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_IRQ  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUSH   = 3'd1;
  localparam logic [2:0] ST_POP    = 3'd2;
  localparam logic [2:0] ST_POP_RD = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_PUSH   = ST_PUSH,
    S_POP    = ST_POP,
    S_POP_RD = ST_POP_RD,
    S_RESP   = ST_RESP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: stack_ctrl_if
// Brief    : Requester-side handshake bundle (core + interrupt unit).
// Revision : 1.0 - initial release
// ============================================================================
interface stack_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             core_req;
  logic             core_op;
  logic [WIDTH-1:0] core_wdata;
  logic             core_ack;
  logic             irq_req;
  logic             irq_op;
  logic [WIDTH-1:0] irq_wdata;
  logic             irq_ack;
  logic [WIDTH-1:0] rd_data;
  logic             resp_err;

  modport master (
    output core_req, core_op, core_wdata, irq_req, irq_op, irq_wdata,
    input  core_ack, irq_ack, rd_data, resp_err
  );

  modport slave (
    input  core_req, core_op, core_wdata, irq_req, irq_op, irq_wdata,
    output core_ack, irq_ack, rd_data, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/stack_ctrl_depth_cnt.sv
`default_nettype none
// ============================================================================
// Module  : stack_depth_cnt
// Brief   : Up/down occupancy counter with full/empty flags.
//           STACK_CTRL_WATERMARK_EN adds the hwm high-water-mark output.
// Revision: 1.0 - initial release
// ============================================================================
module stack_depth_cnt #(
  parameter int NWORDS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     dec,
  input  logic                     err_clr,
  output logic [$clog2(NWORDS):0]  depth,
  output logic                     full,
  output logic                     empty
`ifdef STACK_CTRL_WATERMARK_EN
  ,
  output logic [$clog2(NWORDS):0]  hwm
`endif
);
  localparam int             DW     = $clog2(NWORDS) + 1;
  localparam logic [DW-1:0]  C_FULL = DW'(NWORDS);
  localparam logic [DW-1:0]  C_ONE  = DW'(1);

  logic [DW-1:0] r_depth;

  // Refused operations never strobe inc/dec, so no saturation logic is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (inc && !dec) begin
      r_depth <= r_depth + C_ONE;
    end else if (dec && !inc) begin
      r_depth <= r_depth - C_ONE;
    end
  end

  assign depth = r_depth;
  assign full  = (r_depth == C_FULL);
  assign empty = (r_depth == '0);

`ifdef STACK_CTRL_WATERMARK_EN
  logic [DW-1:0] r_hwm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hwm <= '0;
    end else if (err_clr) begin
      r_hwm <= r_depth;
    end else if (r_depth > r_hwm) begin
      r_hwm <= r_depth;
    end
  end

  assign hwm = r_hwm;
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr;
`endif

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stack_ctrl
// Brief   : Arbitrated push/pop sequencer for the shared hardware stack.
//           STACK_CTRL_WATERMARK_EN adds the hwm high-water-mark output.
// Revision: 1.0 - initial release
// ============================================================================
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int NWORDS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  stack_ctrl_if.slave              bus,
  output logic                     we_stack,
  output logic                     s_pushpop,
  output logic [WIDTH-1:0]         stk_data_in,
  input  logic [WIDTH-1:0]         stk_data_out,
  output logic [$clog2(NWORDS):0]  depth,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_err,
  output logic                     unf_err,
  input  logic                     err_clr
`ifdef STACK_CTRL_WATERMARK_EN
  ,
  output logic [$clog2(NWORDS):0]  hwm
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic             r_err;
  logic             r_we_stack;
  logic             r_pushpop;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stk_din;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_sel_irq;
  logic             w_req;
  logic             w_op;
  logic [WIDTH-1:0] w_wdata;
  logic             w_refuse;
  logic             w_grant;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_full;
  logic             w_empty;
  logic             w_inc;
  logic             w_dec;

  // Fixed priority: the interrupt unit always wins a simultaneous request.
  assign w_sel_irq = bus.irq_req;
  assign w_req     = bus.irq_req | bus.core_req;
  assign w_op      = w_sel_irq ? bus.irq_op    : bus.core_op;
  assign w_wdata   = w_sel_irq ? bus.irq_wdata : bus.core_wdata;
  assign w_refuse  = (w_op == OP_PUSH) ? w_full : w_empty;
  assign w_grant   = (r_state == S_IDLE) && w_req;
  assign w_set_ovf = w_grant && w_refuse && (w_op == OP_PUSH);
  assign w_set_unf = w_grant && w_refuse && (w_op == OP_POP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_refuse)              w_next = S_RESP;
          else if (w_op == OP_PUSH)  w_next = S_PUSH;
          else                       w_next = S_POP;
        end
      end
      S_PUSH:   w_next = S_RESP;
      S_POP:    w_next = S_POP_RD;
      S_POP_RD: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with PUSH/POP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= GNT_CORE;
      r_err      <= 1'b0;
      r_we_stack <= 1'b0;
      r_pushpop  <= OP_PUSH;
      r_stk_din  <= '0;
      r_rd_data  <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_we_stack <= (w_next == S_PUSH) || (w_next == S_POP);
      if (w_grant) begin
        r_owner <= w_sel_irq ? GNT_IRQ : GNT_CORE;
        r_err   <= w_refuse;
      end
      if (w_next == S_PUSH) begin
        r_pushpop <= OP_PUSH;
        r_stk_din <= w_wdata;
      end else if (w_next == S_POP) begin
        r_pushpop <= OP_POP;
      end
      if (r_state == S_POP_RD) begin
        r_rd_data <= stk_data_out;
      end
      r_ovf <= w_set_ovf | (r_ovf & ~err_clr);
      r_unf <= w_set_unf | (r_unf & ~err_clr);
    end
  end

  assign w_inc = (r_state == S_PUSH);
  assign w_dec = (r_state == S_POP);

  stack_depth_cnt #(
    .NWORDS (NWORDS)
  ) u_depth_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_inc),
    .dec     (w_dec),
    .err_clr (err_clr),
    .depth   (depth),
    .full    (w_full),
    .empty   (w_empty)
`ifdef STACK_CTRL_WATERMARK_EN
    ,
    .hwm     (hwm)
`endif
  );

  assign bus.core_ack = (r_state == S_RESP) && (r_owner == GNT_CORE);
  assign bus.irq_ack  = (r_state == S_RESP) && (r_owner == GNT_IRQ);
  assign bus.resp_err = (r_state == S_RESP) && r_err;
  assign bus.rd_data  = r_rd_data;
  assign we_stack     = r_we_stack;
  assign s_pushpop    = r_pushpop;
  assign stk_data_in  = r_stk_din;
  assign full         = w_full;
  assign empty        = w_empty;
  assign ovf_err      = r_ovf;
  assign unf_err      = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_stack_ctrl
// Brief   : Directed + random bench for stack_ctrl against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int WIDTH  = 10;
  localparam int NWORDS = 16;
  localparam int DW     = $clog2(NWORDS) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             we_stack;
  logic             s_pushpop;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             unf_err;
  logic             err_clr;
`ifdef STACK_CTRL_WATERMARK_EN
  logic [DW-1:0]    hwm;
`endif

  stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

  stack_ctrl #(
    .WIDTH  (WIDTH),
    .NWORDS (NWORDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .we_stack     (we_stack),
    .s_pushpop    (s_pushpop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .depth        (depth),
    .full         (full),
    .empty        (empty),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err),
    .err_clr      (err_clr)
`ifdef STACK_CTRL_WATERMARK_EN
    ,
    .hwm          (hwm)
`endif
  );

  always #5 clk = ~clk;

  // Stack memory with its pointer, reset from the same source as the controller.
  logic [WIDTH-1:0] mem [NWORDS];
  logic [DW-1:0]    sp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (we_stack) begin
      if (!s_pushpop) begin
        mem[sp[DW-2:0]] <= stk_data_in;
        sp <= sp + 1'b1;
      end else begin
        sp <= sp - 1'b1;
      end
    end
  end

  assign stk_data_out = mem[sp[DW-2:0]];

  // Reference model
  logic [WIDTH-1:0] model [$];
  logic [WIDTH-1:0] exp_rd;
  logic             exp_ovf;
  logic             exp_unf;
  int               checks;
  int               failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_depth"}, 32'(depth), 32'(model.size()));
    check({tag, "_full"},  32'(full),  32'(model.size() == NWORDS));
    check({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
    check({tag, "_ovf"},   32'(ovf_err), 32'(exp_ovf));
    check({tag, "_unf"},   32'(unf_err), 32'(exp_unf));
  endtask

  // Issue one request at the start of an IDLE cycle and check the whole response.
  task automatic do_op(input bit irq, input logic op, input logic [WIDTH-1:0] data,
                       input bit clr);
    bit   refused;
    int   exp_lat;
    int   lat;
    int   we_cnt;
    logic we_pp;
    refused = (op == OP_PUSH) ? (model.size() == NWORDS) : (model.size() == 0);
    exp_lat = refused ? 1 : ((op == OP_PUSH) ? 2 : 3);
    if (irq) begin
      bus.irq_req = 1'b1; bus.irq_op = op; bus.irq_wdata = data;
    end else begin
      bus.core_req = 1'b1; bus.core_op = op; bus.core_wdata = data;
    end
    err_clr = clr;
    lat = -1; we_cnt = 0; we_pp = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 1) err_clr = 1'b0;
      if (we_stack) begin
        we_cnt++;
        we_pp = s_pushpop;
      end
      if (bus.core_ack || bus.irq_ack) begin
        lat = n;
        break;
      end
    end
    err_clr = 1'b0;
    if (clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
    if (refused) begin
      if (op == OP_PUSH) exp_ovf = 1'b1;
      else               exp_unf = 1'b1;
    end else if (op == OP_PUSH) begin
      model.push_back(data);
    end else begin
      exp_rd = model.pop_back();
    end
    check("latency",   32'(lat), 32'(exp_lat));
    check("own_ack",   32'(irq ? bus.irq_ack : bus.core_ack), 32'(1));
    check("other_ack", 32'(irq ? bus.core_ack : bus.irq_ack), 32'(0));
    check("resp_err",  32'(bus.resp_err), 32'(refused));
    check("we_pulses", 32'(we_cnt), 32'(refused ? 0 : 1));
    if (!refused) check("s_pushpop", 32'(we_pp), 32'(op));
    if (op == OP_POP) check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    check_status("op");
    bus.irq_req  = 1'b0;
    bus.core_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_depth"}, 32'(depth), 32'(0));
    check({tag, "_empty"}, 32'(empty), 32'(1));
    check({tag, "_full"},  32'(full), 32'(0));
    check({tag, "_acks"},  32'({bus.core_ack, bus.irq_ack}), 32'(0));
    check({tag, "_we"},    32'(we_stack), 32'(0));
    check({tag, "_pp"},    32'(s_pushpop), 32'(0));
    check({tag, "_rerr"},  32'(bus.resp_err), 32'(0));
    check({tag, "_flags"}, 32'({ovf_err, unf_err}), 32'(0));
    check({tag, "_rd"},    32'(bus.rd_data), 32'(0));
    check({tag, "_sdin"},  32'(stk_data_in), 32'(0));
  endtask

  initial begin
    int   ia;
    int   ca;
    bit   acked;
    logic [WIDTH-1:0] da;
    logic [WIDTH-1:0] db;

    checks = 0; failures = 0;
    exp_rd = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    bus.core_req = 1'b0; bus.core_op = OP_PUSH; bus.core_wdata = '0;
    bus.irq_req  = 1'b0; bus.irq_op  = OP_PUSH; bus.irq_wdata  = '0;
    err_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Basic round trip
    do_op(1'b0, OP_PUSH, 10'h155, 1'b0);
    do_op(1'b0, OP_POP,  10'h000, 1'b0);

    // Fill, overflow, drain in LIFO order
    for (int i = 0; i < NWORDS; i++) do_op(1'b0, OP_PUSH, WIDTH'(i), 1'b0);
    do_op(1'b0, OP_PUSH, 10'h3FF, 1'b0);
    for (int i = 0; i < NWORDS; i++) do_op(1'b0, OP_POP, '0, 1'b0);

    // Underflow keeps rd_data; set beats a simultaneous clear
    do_op(1'b0, OP_PUSH, 10'h3C3, 1'b0);
    do_op(1'b0, OP_POP,  '0, 1'b0);
    do_op(1'b0, OP_POP,  '0, 1'b0);
    do_op(1'b1, OP_POP,  '0, 1'b1);

    // Plain clear pulse
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    check_status("clear");

    // Simultaneous requests: irq first, core after one IDLE cycle
    da = 10'h0A5; db = 10'h15A;
    bus.irq_req = 1'b1;  bus.irq_op = OP_PUSH;  bus.irq_wdata = da;
    bus.core_req = 1'b1; bus.core_op = OP_PUSH; bus.core_wdata = db;
    ia = -1; ca = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.irq_ack) begin
        ia = n;
        bus.irq_req = 1'b0;
      end
      if (bus.core_ack) begin
        ca = n;
        bus.core_req = 1'b0;
        break;
      end
    end
    bus.irq_req = 1'b0; bus.core_req = 1'b0;
    check("dual_irq_lat",  32'(ia), 32'(2));
    check("dual_core_lat", 32'(ca), 32'(5));
    model.push_back(da);
    model.push_back(db);
    @(posedge clk); #1;
    check_status("dual");
    do_op(1'b0, OP_POP, '0, 1'b0);
    do_op(1'b1, OP_POP, '0, 1'b0);

    // Reset asserted while in POP
    do_op(1'b0, OP_PUSH, 10'h111, 1'b0);
    do_op(1'b0, OP_PUSH, 10'h222, 1'b0);
    bus.core_req = 1'b1; bus.core_op = OP_POP;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_pop", 32'({we_stack, s_pushpop}), 32'(2'b11));
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    bus.core_req = 1'b0;
    acked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.core_ack || bus.irq_ack) acked = 1'b1;
    end
    check("midrst_noack", 32'(acked), 32'(0));
    reset = 1'b1;
    model.delete();
    exp_rd = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, OP_PUSH, 10'h2AA, 1'b0);
    do_op(1'b0, OP_POP,  '0, 1'b0);

`ifdef STACK_CTRL_WATERMARK_EN
    for (int i = 0; i < 5; i++) do_op(1'b0, OP_PUSH, WIDTH'(i + 32), 1'b0);
    for (int i = 0; i < 3; i++) do_op(1'b1, OP_POP, '0, 1'b0);
    check("hwm_peak", 32'(hwm), 32'(5));
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("hwm_clr", 32'(hwm), 32'(2));
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 55) ? OP_PUSH : OP_POP,
            WIDTH'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Controller and arbiter for the hardware stack (push/pop memory plus stack pointer).
- Shares the stack between two requesters: the core (CALL/RET, PUSH/POP instructions) and the interrupt unit (save/restore on IRQ entry/RETI).
- Sequences the stack strobes, tracks depth, blocks overflow/underflow and returns pop data through a req/ack handshake.

Parameters:
- WIDTH, 10, stack word width in bits.
- NWORDS, 16, stack depth in words (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core request, level; held until core_ack.
- core_op  in  1  0=push, 1=pop.
- core_wdata  in  WIDTH  push data from core.
- core_ack  out  1  one-cycle completion pulse to core.
- irq_req  in  1  interrupt-unit request, level; held until irq_ack.
- irq_op  in  1  0=push, 1=pop.
- irq_wdata  in  WIDTH  push data from interrupt unit.
- irq_ack  out  1  one-cycle completion pulse to interrupt unit.
- rd_data  out  WIDTH  pop result, registered; valid in the ack cycle and held until the next pop.
- resp_err  out  1  high with ack when the operation was refused.
- we_stack  out  1  stack operation strobe.
- s_pushpop  out  1  0=push (write, SP+1), 1=pop (SP-1).
- stk_data_in  out  WIDTH  data to stack memory.
- stk_data_out  in  WIDTH  read data from stack memory at current SP.
- depth  out  $clog2(NWORDS)+1  words currently stored.
- full  out  1  depth==NWORDS.
- empty  out  1  depth==0.
- ovf_err  out  1  sticky overflow flag.
- unf_err  out  1  sticky underflow flag.
- err_clr  in  1  synchronous clear of the sticky flags.

Behaviour:
- Reset (reset=0, async): state=IDLE; depth=0; empty=1; full=0; all acks, we_stack, resp_err, ovf_err and unf_err =0; s_pushpop=0; rd_data=0; stk_data_in=0.
- The top level drives the stack pointer's reset from the same source, so SP and depth stay aligned. Reset mid-operation aborts the operation with no ack.
- FSM states: IDLE, PUSH, POP, POP_RD, RESP.
- IDLE:
  - If irq_req: grant the interrupt unit (fixed priority). Else if core_req: grant the core.
  - Latch grant owner, op and wdata.
  - Push when full, or pop when empty: go to RESP with err=1 and no stack strobe.
  - Otherwise go to PUSH or POP.
- PUSH: we_stack=1, s_pushpop=0, stk_data_in=latched wdata; depth+1; go to RESP.
- POP: we_stack=1, s_pushpop=1; depth-1; go to POP_RD.
- POP_RD: SP has settled; capture stk_data_out into rd_data; go to RESP.
- RESP: pulse the owner's ack (and resp_err if refused); go to IDLE.
- Latency from request visible in IDLE to ack: push 2 cycles, pop 3 cycles, refused 1 cycle. One IDLE cycle always separates operations.
- we_stack and s_pushpop are registered Moore outputs, high for exactly one cycle per operation; s_pushpop keeps its last value otherwise.
- A request arriving while busy waits. A request from the losing requester in the same cycle is served next unless the winner re-requests; IRQ can starve the core by design.
- Refused push sets ovf_err; refused pop sets unf_err and leaves rd_data unchanged. If err_clr and a set occur in the same cycle, set wins.
- depth never wraps: counter saturates by construction because refused operations do not change it.

Optional Feature:
- STACK_CTRL_WATERMARK_EN defined: adds output hwm [$clog2(NWORDS):0], the maximum depth since reset, updated the cycle after depth rises. err_clr also resets hwm to the current depth.
- Undefined: no hwm port and no extra logic.

Decomposition:
- Package stack_pkg holds:
  - Op codes OP_PUSH=1'b0, OP_POP=1'b1.
  - FSM state encoding localparams.
  - Requester IDs GNT_CORE and GNT_IRQ.
- One sub-module, stack_depth_cnt: up/down depth counter with full/empty compare and optional watermark.

Test Plan:
- Reset, core push 0x155 -> we_stack/s_pushpop=0 one cycle, core_ack 2 cycles after req, depth=1; core pop -> rd_data=0x155, core_ack at 3 cycles, depth=0, empty=1.
- Push 16 words 0..15 -> full=1. 17th push -> core_ack+resp_err same cycle, no we_stack, ovf_err=1. Pop 16 -> LIFO order 15..0.
- Pop on empty -> ack+resp_err, unf_err=1, rd_data unchanged. err_clr asserted together with a second failed pop -> unf_err stays 1.
- core_req and irq_req raised the same cycle -> irq served first, core ack follows with one IDLE gap.
- reset pulsed low during the POP state -> no ack, depth=0, outputs at reset values; next push/pop round-trip is correct.
- With STACK_CTRL_WATERMARK_EN: push 5, pop 3 -> hwm=5; err_clr -> hwm=2.
